// File: rtl/mem_handle_responder.sv
// mem_handle_responder: memory-side responder for one mem_handle port.
// Serves ptr/r_en/w_en/avail requests from a local word-addressed scratchpad
// covering [region_begin, region_end), with optional read/write-through to a
// backing memory over a req/ack bus.
// Ports:
//   clk, rst_l                      clock, async active-low reset
//   cfg_load, region_begin_i/_end_i region configuration (applied in IDLE only)
//   region_begin, region_end        latched region bounds
//   ptr, r_en, w_en, avail          request (held by initiator until done)
//   read_through, write_through     backing-memory routing flags
//   data_store / data_load          write data / read data
//   done                            request complete, held while avail high
//   bk_req/bk_we/bk_addr/bk_wdata   backing request (held until bk_ack)
//   bk_ack/bk_rdata                 backing completion and read data
//   err                             sticky error flag
module mem_handle_responder #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] region_begin_i,
  input  logic [ADDR_W-1:0] region_end_i,
  output logic [ADDR_W-1:0] region_begin,
  output logic [ADDR_W-1:0] region_end,
  input  logic [ADDR_W-1:0] ptr,
  input  logic              r_en,
  input  logic              w_en,
  input  logic              avail,
  input  logic              read_through,
  input  logic              write_through,
  input  logic [DATA_W-1:0] data_store,
  output logic              done,
  output logic [DATA_W-1:0] data_load,
  output logic              bk_req,
  output logic              bk_we,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [DATA_W-1:0] bk_wdata,
  input  logic              bk_ack,
  input  logic [DATA_W-1:0] bk_rdata,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_SRAM_RD = 3'd2,
    S_BK_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_load_q, data_load_d;
  logic              bk_req_q, bk_req_d;
  logic              bk_we_q, bk_we_d;
  logic [ADDR_W-1:0] bk_addr_q, bk_addr_d;
  logic [DATA_W-1:0] bk_wdata_q, bk_wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] region_begin_q, region_begin_d;
  logic [ADDR_W-1:0] region_end_q, region_end_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic [ADDR_W-1:0] index_c;
  logic [IDX_W-1:0]  idx_c;
  logic              in_range_c;
  logic              mem_we_c;
  logic              mem_re_c;

  // Region-relative index; only meaningful when ptr >= region_begin.
  assign index_c    = ptr - region_begin_q;
  assign idx_c      = IDX_W'(index_c);
  assign in_range_c = (ptr >= region_begin_q) && (ptr < region_end_q) &&
                      (index_c < ADDR_W'(DEPTH));

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    data_load_d    = data_load_q;
    bk_req_d       = bk_req_q;
    bk_we_d        = bk_we_q;
    bk_addr_d      = bk_addr_q;
    bk_wdata_d     = bk_wdata_q;
    err_d          = err_q;
    region_begin_d = region_begin_q;
    region_end_d   = region_end_q;
    mem_we_c       = 1'b0;
    mem_re_c       = 1'b0;

    // Reconfiguring mid-request would change the range under it, so reject it.
    if (cfg_load) begin
      if (state_q == S_IDLE) begin
        region_begin_d = region_begin_i;
        region_end_d   = region_end_i;
        err_d          = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (avail && (r_en || w_en)) state_d = S_DECODE;
      end
      // All request inputs are sampled here and nowhere else.
      S_DECODE: begin
        data_load_d = '0;
        if (r_en && w_en) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else if (r_en && read_through) begin
          bk_req_d   = 1'b1;
          bk_we_d    = 1'b0;
          bk_addr_d  = ptr;
          bk_wdata_d = '0;
          state_d    = S_BK_WAIT;
        end else if (w_en && write_through) begin
          // Local leg is range-checked; backing leg always proceeds.
          if (in_range_c) mem_we_c = 1'b1;
          else            err_d    = 1'b1;
          bk_req_d   = 1'b1;
          bk_we_d    = 1'b1;
          bk_addr_d  = ptr;
          bk_wdata_d = data_store;
          state_d    = S_BK_WAIT;
        end else if (!in_range_c) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_RESP;
        end else if (w_en) begin
          mem_we_c = 1'b1;
          done_d   = 1'b1;
          state_d  = S_RESP;
        end else begin
          mem_re_c = 1'b1;
          state_d  = S_SRAM_RD;
        end
      end
      S_SRAM_RD: begin
        data_load_d = rd_data_q;
        done_d      = 1'b1;
        state_d     = S_RESP;
      end
      S_BK_WAIT: begin
        if (bk_ack) begin
          bk_req_d = 1'b0;
          done_d   = 1'b1;
          if (!bk_we_q) data_load_d = bk_rdata;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (!avail) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q        <= S_IDLE;
      done_q         <= 1'b0;
      data_load_q    <= '0;
      bk_req_q       <= 1'b0;
      bk_we_q        <= 1'b0;
      bk_addr_q      <= '0;
      bk_wdata_q     <= '0;
      err_q          <= 1'b0;
      region_begin_q <= '0;
      region_end_q   <= '0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      data_load_q    <= data_load_d;
      bk_req_q       <= bk_req_d;
      bk_we_q        <= bk_we_d;
      bk_addr_q      <= bk_addr_d;
      bk_wdata_q     <= bk_wdata_d;
      err_q          <= err_d;
      region_begin_q <= region_begin_d;
      region_end_q   <= region_end_d;
    end
  end

  // Scratchpad array: one synchronous write or read port, no reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= data_store;
    if (mem_re_c) rd_data_q <= mem[idx_c];
  end

  assign done         = done_q;
  assign data_load    = data_load_q;
  assign bk_req       = bk_req_q;
  assign bk_we        = bk_we_q;
  assign bk_addr      = bk_addr_q;
  assign bk_wdata     = bk_wdata_q;
  assign err          = err_q;
  assign region_begin = region_begin_q;
  assign region_end   = region_end_q;

endmodule

// File: tb/tb_mem_handle_responder.sv
// Testbench for mem_handle_responder: table-driven request vectors plus
// hand-written sequences for copy loop, region config corners and reset.
module tb_mem_handle_responder;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        cfg_load;
  logic [31:0] region_begin_i, region_end_i, region_begin, region_end;
  logic [31:0] ptr;
  logic        r_en, w_en, avail, read_through, write_through;
  logic [31:0] data_store, data_load;
  logic        done;
  logic        bk_req, bk_we, bk_ack;
  logic [31:0] bk_addr, bk_wdata, bk_rdata;
  logic        err;

  mem_handle_responder dut (
    .clk(clk), .rst_l(rst_l), .cfg_load(cfg_load),
    .region_begin_i(region_begin_i), .region_end_i(region_end_i),
    .region_begin(region_begin), .region_end(region_end),
    .ptr(ptr), .r_en(r_en), .w_en(w_en), .avail(avail),
    .read_through(read_through), .write_through(write_through),
    .data_store(data_store), .done(done), .data_load(data_load),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
    .bk_ack(bk_ack), .bk_rdata(bk_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Backing memory model: acks after bk_delay cycles of bk_req, records the request.
  int          bk_delay = 1000;
  logic [31:0] bk_resp  = 32'h0;
  int          bk_cur   = 0;
  int          bk_tot   = 0;
  int          bk_unstable = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;

  initial begin
    bk_ack   = 1'b0;
    bk_rdata = 32'h0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      bk_ack = 1'b0;
      if (bk_req) begin
        bk_cur++;
        bk_tot++;
        if (bk_cur == 1) begin
          cap_addr = bk_addr; cap_we = bk_we; cap_wdata = bk_wdata;
        end else if (bk_addr !== cap_addr || bk_we !== cap_we || bk_wdata !== cap_wdata) begin
          bk_unstable++;
        end
        if (bk_cur == bk_delay) begin
          bk_ack   = 1'b1;
          bk_rdata = bk_resp;
        end
      end else begin
        bk_cur = 0;
      end
    end
  end

  // Issue a request at a negedge; returns edges until done is observed.
  // ptr/data_store are scrambled after the decode edge to prove they are ignored.
  task automatic do_req(input logic [31:0] p, input logic r, input logic w,
                        input logic rt, input logic wt, input logic [31:0] d,
                        output int edges);
    ptr = p; r_en = r; w_en = w; read_through = rt; write_through = wt;
    data_store = d; avail = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 2) begin ptr = ~p; data_store = ~d; end
    end while (!done && edges < 60);
  endtask

  // Drop avail; done must clear on the very next edge.
  task automatic finish_req(input string name);
    avail = 1'b0; r_en = 1'b0; w_en = 1'b0;
    read_through = 1'b0; write_through = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_done_clear"}, 32'(done), 32'h0);
  endtask

  task automatic cfg(input logic [31:0] b, input logic [31:0] e);
    cfg_load = 1'b1; region_begin_i = b; region_end_i = e;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] p;
    logic        r, w, rt, wt;
    logic [31:0] d;
    int          dly;
    logic [31:0] bkr;
    int          exp_edges;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_bk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          edges;
    int          tot0, uns0;
    logic [31:0] exp;

    // Region 0x100..0x140 is used by every vector.
    vecs[0] = '{"wr_105",    32'h105,  1'b0,1'b1,1'b0,1'b0, 32'hDEADBEEF, 1, 32'h0,    2, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{"rd_105",    32'h105,  1'b1,1'b0,1'b0,1'b0, 32'h0,        1, 32'h0,    3, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{"rt_2000",   32'h2000, 1'b1,1'b0,1'b1,1'b0, 32'h0,        5, 32'h1234, 7, 32'h1234,     1'b0, 1'b1};
    vecs[3] = '{"wt_13f",    32'h13F,  1'b0,1'b1,1'b0,1'b1, 32'hA5A5,     3, 32'h0,    5, 32'h0,        1'b0, 1'b1};
    vecs[4] = '{"rd_13f",    32'h13F,  1'b1,1'b0,1'b0,1'b0, 32'h0,        1, 32'h0,    3, 32'hA5A5,     1'b0, 1'b0};
    vecs[5] = '{"rd_end",    32'h140,  1'b1,1'b0,1'b0,1'b0, 32'h0,        1, 32'h0,    2, 32'h0,        1'b1, 1'b0};
    vecs[6] = '{"rw_both",   32'h105,  1'b1,1'b1,1'b0,1'b0, 32'h1111,     1, 32'h0,    2, 32'h0,        1'b1, 1'b0};
    vecs[7] = '{"rd_105b",   32'h105,  1'b1,1'b0,1'b0,1'b0, 32'h0,        1, 32'h0,    3, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[8] = '{"wr_below",  32'hFF,   1'b0,1'b1,1'b0,1'b0, 32'h7777,     1, 32'h0,    2, 32'h0,        1'b1, 1'b0};
    vecs[9] = '{"rt_wrap",   32'h0,    1'b1,1'b0,1'b1,1'b0, 32'h0,        1, 32'hCAFE, 3, 32'hCAFE,     1'b0, 1'b1};

    rst_l = 1'b0; cfg_load = 1'b0; region_begin_i = '0; region_end_i = '0;
    ptr = '0; r_en = 1'b0; w_en = 1'b0; avail = 1'b0;
    read_through = 1'b0; write_through = 1'b0; data_store = '0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_bk_req", 32'(bk_req), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_data_load", data_load, 32'h0);
    chk("rst_region_end", region_end, 32'h0);

    // avail without r_en/w_en is ignored.
    avail = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_avail_done", 32'(done), 32'h0);
    avail = 1'b0;

    cfg(32'h100, 32'h140);
    chk("cfg_begin", region_begin, 32'h100);
    chk("cfg_end", region_end, 32'h140);

    for (int i = 0; i < 10; i++) begin
      bk_delay = vecs[i].dly;
      bk_resp  = vecs[i].bkr;
      tot0 = bk_tot;
      uns0 = bk_unstable;
      do_req(vecs[i].p, vecs[i].r, vecs[i].w, vecs[i].rt, vecs[i].wt, vecs[i].d, edges);
      chk({vecs[i].name, "_edges"}, 32'(edges), 32'(vecs[i].exp_edges));
      chk({vecs[i].name, "_data"}, data_load, vecs[i].exp_data);
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_bk_req_now"}, 32'(bk_req), 32'h0);
      if (vecs[i].exp_bk) begin
        chk({vecs[i].name, "_bk_cycles"}, 32'(bk_tot - tot0), 32'(vecs[i].dly));
        chk({vecs[i].name, "_bk_addr"}, cap_addr, vecs[i].p);
        chk({vecs[i].name, "_bk_we"}, 32'(cap_we), 32'(vecs[i].wt));
        if (vecs[i].wt) chk({vecs[i].name, "_bk_wdata"}, cap_wdata, vecs[i].d);
        chk({vecs[i].name, "_bk_stable"}, 32'(bk_unstable - uns0), 32'h0);
      end else begin
        chk({vecs[i].name, "_no_bk"}, 32'(bk_tot - tot0), 32'h0);
      end
      finish_req(vecs[i].name);
      if (vecs[i].exp_err) begin
        cfg(32'h100, 32'h140);
        chk({vecs[i].name, "_err_cleared"}, 32'(err), 32'h0);
      end
    end

    // Copy-style loop: back-to-back writes then reads over the whole region.
    for (int i = 0; i < 64; i++) begin
      do_req(32'h100 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0, 32'hC0DE0000 + 32'(i * 7), edges);
      chk($sformatf("copy_wr%0d_edges", i), 32'(edges), 32'd2);
      finish_req($sformatf("copy_wr%0d", i));
    end
    for (int i = 0; i < 64; i++) begin
      do_req(32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, edges);
      exp = 32'hC0DE0000 + 32'(i * 7);
      chk($sformatf("copy_rd%0d_data", i), data_load, exp);
      finish_req($sformatf("copy_rd%0d", i));
    end
    chk("copy_err", 32'(err), 32'h0);

    // cfg_load during DECODE is dropped and flags err; the request still completes.
    ptr = 32'h105; r_en = 1'b1; avail = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b1; region_begin_i = 32'h0; region_end_i = 32'h10;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
    edges = 2;
    while (!done && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("busycfg_edges", 32'(edges), 32'd3);
    chk("busycfg_data", data_load, 32'hC0DE0000 + 32'(5 * 7));
    chk("busycfg_err", 32'(err), 32'h1);
    chk("busycfg_begin", region_begin, 32'h100);
    finish_req("busycfg");

    // Empty region: every local access is out of range.
    cfg(32'h200, 32'h200);
    do_req(32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, edges);
    chk("empty_edges", 32'(edges), 32'd2);
    chk("empty_err", 32'(err), 32'h1);
    finish_req("empty");
    cfg(32'h100, 32'h140);

    // Asynchronous reset in BK_WAIT drops bk_req immediately.
    bk_delay = 1000;
    ptr = 32'h3000; r_en = 1'b1; read_through = 1'b1; avail = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstmid_bk_req_before", 32'(bk_req), 32'h1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("rstmid_bk_req", 32'(bk_req), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    avail = 1'b0; r_en = 1'b0; read_through = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_done_after", 32'(done), 32'h0);
    chk("rstmid_region_begin", region_begin, 32'h0);
    chk("rstmid_bk_addr", bk_addr, 32'h0);
    cfg(32'h100, 32'h140);
    do_req(32'h120, 1'b0, 1'b1, 1'b0, 1'b0, 32'h600DF00D, edges);
    chk("rstmid_wr_edges", 32'(edges), 32'd2);
    finish_req("rstmid_wr");
    do_req(32'h120, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, edges);
    chk("rstmid_rd_edges", 32'(edges), 32'd3);
    chk("rstmid_rd_data", data_load, 32'h600DF00D);
    chk("rstmid_err", 32'(err), 32'h0);
    finish_req("rstmid_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
